// File: rtl/accu_pkg.sv
// rtl/accu_pkg.sv - shared mode encoding for the integrate-and-dump accumulator
package accu_pkg;

    typedef enum logic [1:0] {
        WRAP = 2'd0,
        SAT  = 2'd1,
        MOD  = 2'd2,
        RSVD = 2'd3
    } accu_mode_e;

endpackage

// File: rtl/accu_step.sv
// rtl/accu_step.sv - combinational single-sample update for wrap, saturate and modulo-M
module accu_step
    import accu_pkg::*;
#(
    parameter int AW = 24,
    parameter int M  = 50
) (
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] d,
    input  accu_mode_e    mode,
    output logic [AW-1:0] acc_next,
    output logic          carry,
    output logic          ovf_ev,
    output logic          err_ev
);

    // M may equal 2**AW, so it needs the extra bit alongside the sum
    localparam logic [AW:0] M_W = (AW+1)'(M);

    logic [AW:0] s;

    always_comb begin
        s        = {1'b0, acc} + {1'b0, d};
        acc_next = s[AW-1:0];
        carry    = 1'b0;
        ovf_ev   = 1'b0;
        err_ev   = 1'b0;
        case (mode)
            SAT: begin
                if (s[AW]) begin
                    acc_next = '1;
                    carry    = 1'b1;
                    ovf_ev   = 1'b1;
                end
            end
            MOD: begin
                if ({1'b0, d} >= M_W) begin
                    acc_next = acc;
                    err_ev   = 1'b1;
                end else if (s >= M_W) begin
                    acc_next = AW'(s - M_W);
                    carry    = 1'b1;
                end
            end
            default: begin
                carry  = s[AW];
                ovf_ev = s[AW];
            end
        endcase
    end

endmodule

// File: rtl/accu_dump.sv
// rtl/accu_dump.sv - integrate-and-dump accumulator with valid/ready result register
module accu_dump
    import accu_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 24,
    parameter int M  = 50,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  d,
    input  logic [1:0]    mode,
    input  logic          clr,
    input  logic [CW-1:0] dump_len,
    output logic [AW-1:0] acc,
    output logic          carry,
    output logic          ovf,
    output logic          err,
    output logic          out_valid,
    output logic [AW-1:0] out_data,
    input  logic          out_ready,
    output logic          lost
);

    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    accu_mode_e    mode_q, mode_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          lost_q, lost_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_data_q, out_data_d;

    accu_mode_e    mode_in;
    logic          accept;
    logic          restart;
    logic [AW-1:0] acc_base;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] dump_last;
    logic          dump_hit;
    logic          dump_fire;
    logic [AW-1:0] step_next;
    logic          step_carry;
    logic          step_ovf;
    logic          step_err;

    assign mode_in   = accu_mode_e'(mode);
    assign accept    = en && !clr;
    assign restart   = accept && (mode_in != mode_q);
    assign acc_base  = restart ? '0 : acc_q;
    assign cnt_base  = restart ? '0 : cnt_q;
    // >= rather than == so shrinking dump_len mid-run dumps on the next sample
    assign dump_last = dump_len - CW'(1);
    assign dump_hit  = (dump_len != '0) && (cnt_base >= dump_last);
    assign dump_fire = accept && !step_err && dump_hit;

    accu_step #(
        .AW (AW),
        .M  (M)
    ) u_step (
        .acc      (acc_base),
        .d        (AW'(d)),
        .mode     (mode_in),
        .acc_next (step_next),
        .carry    (step_carry),
        .ovf_ev   (step_ovf),
        .err_ev   (step_err)
    );

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        carry_d     = 1'b0;
        ovf_d       = ovf_q;
        err_d       = err_q;
        lost_d      = lost_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            err_d = 1'b0;
        end else if (en) begin
            mode_d = mode_in;
            if (step_err) begin
                err_d = 1'b1;
                acc_d = acc_base;
                cnt_d = cnt_base;
            end else begin
                carry_d = step_carry;
                if (step_ovf) begin
                    ovf_d = 1'b1;
                end
                if (dump_hit) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_base + CW'(1);
                end
            end
        end

        // result register runs on its own handshake, unaffected by clr
        if (dump_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = step_next;
            if (out_valid_q && !out_ready) begin
                lost_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= WRAP;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign acc       = acc_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign lost      = lost_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/accu_dump.md
Name: accu_dump

Overview:
Parametrised integrate-and-dump accumulator. Successor to the fixed-width and modulo-M accumulators. Sums input samples in one of three run-time modes: wrap, saturate or modulo-M. After a programmable number of accepted samples it dumps the sum to a valid/ready output register and restarts from zero. It sits between sample sources (counters, ADC front-ends) and downstream averaging or reporting logic.

Parameters:
W, 16, input sample width
AW, 24, accumulator width; must be >= W and >= $clog2(M)
M, 50, modulus for MOD mode; 2 <= M <= 2**AW
CW, 8, width of dump_len and the internal sample counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  sample valid; d is accepted when en=1 and clr=0
d  in  W  sample, unsigned, zero-extended to AW
mode  in  2  0=WRAP, 1=SAT, 2=MOD, 3=reserved (behaves as WRAP)
clr  in  1  synchronous clear of the accumulation state
dump_len  in  CW  samples per dump; 0 = never dump (free-running)
acc  out  AW  running accumulator, registered
carry  out  1  one-cycle pulse: the last update wrapped, clamped or mod-wrapped
ovf  out  1  sticky: a WRAP carry-out or a SAT clamp has occurred
err  out  1  sticky: a MOD-mode sample had d >= M
out_valid  out  1  dump result valid
out_data  out  AW  dump result
out_ready  in  1  downstream accept
lost  out  1  sticky: an unaccepted dump was overwritten

Behaviour:
- Reset (rst=1 at a clk edge): acc=0, cnt=0, carry=0, ovf=0, err=0, lost=0, out_valid=0, out_data=0, mode_q=WRAP. rst overrides every other input.
- Priority each cycle: rst > clr > mode change > en. Output handshake is independent of all three except rst.
- clr=1: acc=0, cnt=0, ovf=0, err=0, carry=0. Any sample presented that cycle is dropped. Output register, out_valid and lost are untouched.
- Mode change: mode is registered into mode_q when a sample is accepted. If an accepted sample arrives with mode != mode_q, the accumulation restarts (acc treated as 0 before adding d, cnt reset to 0), and mode_q updates. ovf and err are kept.
- Update latency 1: on an accepted sample, acc takes acc_next at the next edge.
- Update in WRAP mode: s = acc + d as AW+1 bits. acc_next = s[AW-1:0]. carry = s[AW]. If s[AW]=1, ovf is set.
- Update in SAT mode: if s > 2**AW-1 then acc_next = 2**AW-1, carry=1, ovf is set. Otherwise acc_next = s.
- Update in MOD mode (acc < M holds as an invariant): if d >= M, the sample is ignored (acc and cnt unchanged), err is set, carry=0. Otherwise acc_next = s; if s >= M, acc_next = s - M and carry=1.
- carry is 0 on every cycle without an accepted update.
- Dump: an accepted sample increments cnt. When dump_len != 0 and cnt == dump_len-1 at acceptance:
  - out_data = acc_next, out_valid = 1 on the next edge;
  - acc = 0 and cnt = 0 (the dumping sample is included in out_data);
  - carry reflects that final update.
- dump_len=1: every accepted sample dumps itself and acc stays 0.
- dump_len changed mid-run: compared live. If cnt is already >= dump_len-1, the next accepted sample dumps.
- Handshake: out_valid falls the edge after out_valid && out_ready.
  - A new dump with the old result still unaccepted (out_valid && !out_ready): out_data is overwritten and lost is set.
  - A new dump in the same cycle as an accept: out_valid stays 1 with the new data, and lost is not set.
- No combinational paths from inputs to outputs.

Decomposition:
- Package accu_pkg: typedef enum logic [1:0] accu_mode_e {WRAP, SAT, MOD, RSVD}.
- Sub-module accu_step (combinational): inputs acc, d, mode, M; outputs acc_next, carry, ovf_ev, err_ev.
- accu_dump holds the registers, counter, mode tracking and output handshake.

Test Plan:
- WRAP, W=16, AW=16, dump_len=0; drive d=0x8000 for 3 samples -> acc 0x8000, 0x0000 with carry pulse and ovf=1, then 0x8000.
- SAT, AW=8, W=8; drive d=200 then d=100 -> acc 200, then 255 with carry=1 and ovf=1. A further d=1 keeps acc at 255 with carry=1.
- MOD, M=50, dump_len=0; feed d=0,1,2,...,12 -> acc follows the running sum mod 50; 13+...; d=60 is ignored with err=1 and acc unchanged.
- Dump, WRAP, dump_len=4, out_ready=1; drive d=1,2,3,4,5 -> out_valid pulses once with out_data=10, acc returns to 0, then acc=5.
- Backpressure, dump_len=2, out_ready=0; drive d=1,1,3,3 -> first out_data=2, then overwritten with 6 and lost=1. Raising out_ready drops out_valid after 1 cycle.
- Priority: en=1, clr=1, d=7 with acc=9 -> acc=0, cnt=0, ovf/err cleared. rst asserted mid-dump -> all outputs take their reset values at the next edge.
